conv_window_buffer: RTL and testbench

Streaming K×K sliding-window generator for the convolution layers. Accepts a raster-order pixel stream, one pixel per `din_vld` beat, and keeps K-1 full-row line buffers plus a K×K window register. It emits one complete window per accepted pixel whose window lies fully inside the frame. It sits between the pixel source and the conv MAC array, and generalises the single-tap delay line to 2-D, multi-row operation with frame tracking.

---
 rtl/conv_window_buffer.sv | 146 ++++++++++++++
 tb/tb_conv_window_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: streaming KxK sliding-window generator.
// Keeps K-1 full-row line buffers plus a KxK shift window. One window is
// emitted per accepted pixel whose window lies entirely inside the frame.
// Optional build macro CONV_WIN_STRIDE2_EN: emit only windows whose top-left
// row and column are both even (stride 2); counters and frame_done unchanged.
module conv_window_buffer #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   din_vld,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH*K*K-1:0]   win,
    output logic                   win_vld,
    output logic [7:0]             win_row,
    output logic [7:0]             win_col,
    output logic                   frame_done
);

    localparam int        WW       = WIDTH * K * K;
    localparam int        CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);
    localparam logic [7:0] K_M1     = 8'(K - 1);

    // Position of the next pixel in the frame
    logic [7:0]       row_r;
    logic [7:0]       col_r;

    // Line buffers: index 0 is the oldest row, K-2 the most recent full row
    logic [WIDTH-1:0] lb_r [K-1][IMG_W];

    // Free-running shift window (updated on every accepted beat) and its next value
    logic [WW-1:0]    sh_r;
    logic [WW-1:0]    sh_next_s;

    // Registered outputs
    logic [WW-1:0]    win_r;
    logic             win_vld_r;
    logic [7:0]       win_row_r;
    logic [7:0]       win_col_r;
    logic             frame_done_r;

    logic [CW-1:0]    idx_s;
    logic [WIDTH-1:0] col_vec_s [K];
    logic             accept_s;
    logic             last_s;
    logic             inside_s;
    logic             win_ok_s;
    logic [7:0]       win_row_s;
    logic [7:0]       win_col_s;

    assign win        = win_r;
    assign win_vld    = win_vld_r;
    assign win_row    = win_row_r;
    assign win_col    = win_col_r;
    assign frame_done = frame_done_r;

    // Beat qualification, frame position decode and window-valid gating
    always_comb begin
        idx_s     = col_r[CW-1:0];
        accept_s  = din_vld & ~clr;
        last_s    = (row_r == ROW_LAST) && (col_r == COL_LAST);
        inside_s  = (row_r >= K_M1) && (col_r >= K_M1);
        win_row_s = row_r - K_M1;
        win_col_s = col_r - K_M1;
`ifdef CONV_WIN_STRIDE2_EN
        win_ok_s  = accept_s && inside_s && !win_row_s[0] && !win_col_s[0];
`else
        win_ok_s  = accept_s && inside_s;
`endif
    end

    // New window column: stored rows at the current column, then the incoming pixel
    always_comb begin
        for (int i = 0; i < K; i++) begin
            col_vec_s[i] = {WIDTH{1'b0}};
        end
        for (int i = 0; i < K - 1; i++) begin
            col_vec_s[i] = lb_r[i][idx_s];
        end
        col_vec_s[K-1] = din;
    end

    // Shift every window row left by one column and append the new column at j=K-1
    always_comb begin
        sh_next_s = sh_r;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                sh_next_s[WIDTH*(i*K+j) +: WIDTH] = sh_r[WIDTH*(i*K+j+1) +: WIDTH];
            end
            sh_next_s[WIDTH*(i*K+K-1) +: WIDTH] = col_vec_s[i];
        end
    end

    // Line buffer column update: rows age by one, the incoming pixel enters the newest row
    always_ff @(posedge clk) begin
        if (rst && accept_s) begin
            for (int k = 0; k < K - 2; k++) begin
                lb_r[k][idx_s] <= lb_r[k+1][idx_s];
            end
            lb_r[K-2][idx_s] <= din;
        end
    end

    // Position counters, shift window and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_r        <= 8'd0;
            col_r        <= 8'd0;
            sh_r         <= {WW{1'b0}};
            win_r        <= {WW{1'b0}};
            win_vld_r    <= 1'b0;
            win_row_r    <= 8'd0;
            win_col_r    <= 8'd0;
            frame_done_r <= 1'b0;
        end else if (clr) begin
            row_r        <= 8'd0;
            col_r        <= 8'd0;
            win_vld_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            win_vld_r    <= win_ok_s;
            frame_done_r <= accept_s && last_s;
            if (accept_s) begin
                sh_r <= sh_next_s;
                if (col_r == COL_LAST) begin
                    col_r <= 8'd0;
                    row_r <= (row_r == ROW_LAST) ? 8'd0 : row_r + 8'd1;
                end else begin
                    col_r <= col_r + 8'd1;
                end
            end
            if (win_ok_s) begin
                win_r     <= sh_next_s;
                win_row_r <= win_row_s;
                win_col_r <= win_col_s;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer (K=3, 5x4 frame).
// A full-frame pixel model predicts each window when a beat is driven and
// pushes it to a queue; a negedge monitor pops and compares on win_vld.
module tb_conv_window_buffer;

    localparam int WIDTH = 8;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int K     = 3;
    localparam int WW    = WIDTH * K * K;
`ifdef CONV_WIN_STRIDE2_EN
    localparam int WPF   = 2;
`else
    localparam int WPF   = 6;
`endif

    typedef struct packed {
        logic [WW-1:0] w;
        logic [7:0]    r;
        logic [7:0]    c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             din_vld;
    logic [WIDTH-1:0] din;
    logic [WW-1:0]    win;
    logic             win_vld;
    logic [7:0]       win_row;
    logic [7:0]       win_col;
    logic             frame_done;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] mem [IMG_H][IMG_W];
    int               m_r;
    int               m_c;
    logic             exp_fd;
    logic             mon_en;
    int               win_cnt;
    int               fd_cnt;
    logic [WW-1:0]    first_win;
    logic [WW-1:0]    next_frame_win;
    int               n_cmp;
    int               n_err;

    logic [WW-1:0]    win_f0;
    logic [WW-1:0]    win_f100;

    conv_window_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din_vld    (din_vld),
        .din        (din),
        .win        (win),
        .win_vld    (win_vld),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: full-frame pixel store, predicts the window for each beat
    task automatic model_beat(input logic v, input logic [WIDTH-1:0] d, input logic c_in);
        exp_t e;
        logic ok;
        if (c_in) begin
            m_r = 0;
            m_c = 0;
        end else if (v) begin
            mem[m_r][m_c] = d;
            ok = (m_r >= K - 1) && (m_c >= K - 1);
`ifdef CONV_WIN_STRIDE2_EN
            ok = ok && (((m_r - K + 1) % 2) == 0) && (((m_c - K + 1) % 2) == 0);
`endif
            if (ok) begin
                e.w = '0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        e.w[WIDTH*(i*K+j) +: WIDTH] = mem[m_r-K+1+i][m_c-K+1+j];
                e.r = 8'(m_r - K + 1);
                e.c = 8'(m_c - K + 1);
                sb_q.push_back(e);
            end
            if (m_c == IMG_W - 1) begin
                m_c = 0;
                m_r = (m_r == IMG_H - 1) ? 0 : m_r + 1;
            end else begin
                m_c = m_c + 1;
            end
        end
    endtask

    // One clock cycle of stimulus; frame_done expectation follows the beat
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic c_in);
        logic is_last;
        is_last = v && !c_in && (m_r == IMG_H - 1) && (m_c == IMG_W - 1);
        din_vld = v;
        din     = d;
        clr     = c_in;
        model_beat(v, d, c_in);
        @(posedge clk);
        #1;
        exp_fd  = is_last;
        din_vld = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic stream(input int base, input int n, input int gap);
        for (int p = 0; p < n; p++) begin
            step(1'b1, 8'(base + p), 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 8'd0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int p = 0; p < n; p++) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic clear_counts();
        win_cnt = 0;
        fd_cnt  = 0;
    endtask

    task automatic end_test(input string tag, input int exp_win, input int exp_frames);
        idle(3);
        check_eq({tag, "_win_count"}, 128'(win_cnt), 128'(exp_win));
        check_eq({tag, "_fd_count"}, 128'(fd_cnt), 128'(exp_frames));
        check_eq({tag, "_first_win"}, 128'(first_win), 128'(win_f0));
        check_eq({tag, "_queue_drained"}, 128'(sb_q.size()), 128'd0);
    endtask

    // Output monitor: frame_done every cycle, window contents on each pulse
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check_eq("frame_done", 128'(frame_done), 128'(exp_fd));
            if (frame_done) fd_cnt++;
            if (win_vld) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_win_vld", 128'd1, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("win", 128'(win), 128'(e.w));
                    check_eq("win_row", 128'(win_row), 128'(e.r));
                    check_eq("win_col", 128'(win_col), 128'(e.c));
                end
                if (win_cnt == 0) first_win = win;
                if (win_cnt == WPF) next_frame_win = win;
                win_cnt++;
            end
        end
    end

    initial begin
        win_f0   = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
        win_f100 = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100};
        n_cmp = 0; n_err = 0; mon_en = 1'b0; exp_fd = 1'b0;
        m_r = 0; m_c = 0; first_win = '0; next_frame_win = '0;
        clear_counts();
        rst = 1'b0; clr = 1'b0; din_vld = 1'b0; din = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("reset_win", 128'(win), 128'd0);
        check_eq("reset_win_vld", 128'(win_vld), 128'd0);
        check_eq("reset_win_row", 128'(win_row), 128'd0);
        check_eq("reset_win_col", 128'(win_col), 128'd0);
        check_eq("reset_frame_done", 128'(frame_done), 128'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic frame, back-to-back pixels
        clear_counts();
        stream(0, 20, 0);
        end_test("basic", WPF, 1);

        // Gapped input: each pixel followed by two idle cycles
        clear_counts();
        stream(0, 20, 2);
        end_test("gapped", WPF, 1);

        // Two frames back-to-back, no gap
        clear_counts();
        stream(0, 20, 0);
        stream(100, 20, 0);
        end_test("b2b", 2 * WPF, 2);
        check_eq("b2b_frame2_first_win", 128'(next_frame_win), 128'(win_f100));

        // clr with a same-cycle beat at pixel 8, then a fresh frame
        clear_counts();
        stream(0, 8, 0);
        step(1'b1, 8'd8, 1'b1);
        stream(0, 20, 0);
        end_test("clr", WPF, 1);

        // Reset for one cycle after pixel 13, then a fresh frame
        stream(0, 14, 0);
        rst = 1'b0;
        din_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_r = 0; m_c = 0; exp_fd = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_win", 128'(win), 128'd0);
        check_eq("rst_mid_win_vld", 128'(win_vld), 128'd0);
        check_eq("rst_mid_win_row", 128'(win_row), 128'd0);
        check_eq("rst_mid_win_col", 128'(win_col), 128'd0);
        check_eq("rst_mid_frame_done", 128'(frame_done), 128'd0);
        @(posedge clk);
        #1;
        clear_counts();
        stream(0, 20, 0);
        end_test("after_rst", WPF, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
